// File: rtl/vjtag_dr_engine.sv
// Virtual JTAG data-register engine: IR decode, DR shifting, auto-incrementing
// memory write/read ports with read prefetch. Define VJTAG_STATUS_EN for STATUS.
module vjtag_dr_engine #(
    parameter int IR_WIDTH   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  tck,
    input  logic                  rst,
    input  logic                  tdi,
    output logic                  tdo,
    input  logic [IR_WIDTH-1:0]   ir_in,
    output logic [IR_WIDTH-1:0]   ir_out,
    input  logic                  virtual_state_cdr,
    input  logic                  virtual_state_sdr,
    input  logic                  virtual_state_udr,
    input  logic                  virtual_state_uir,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [IR_WIDTH-1:0] IR_ADDR  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_WRITE = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] IR_READ  = IR_WIDTH'(3);
`ifdef VJTAG_STATUS_EN
    localparam logic [IR_WIDTH-1:0] IR_STATUS = IR_WIDTH'(4);
    localparam int CNT_W = DATA_WIDTH / 2;
`endif

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_WAIT,
        PF_READY
    } pf_state_t;

    logic [IR_WIDTH-1:0]   active_ir;
    logic                  bypass_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] rd_buf;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wrap;
    logic                  rd_err;
    pf_state_t             pf_state;

    logic                  is_addr;
    logic                  is_write;
    logic                  is_read;
    logic                  is_status;
    logic                  is_bypass;
    logic                  rd_hit;
    pf_state_t             pf_eff;
    logic [DATA_WIDTH-1:0] rd_buf_eff;
    logic                  fetch;
    logic                  addr_inc;
    logic [DATA_WIDTH-1:0] capture_value;

`ifdef VJTAG_STATUS_EN
    logic [CNT_W-1:0]      wr_count;
    logic [CNT_W-1:0]      rd_count;
`endif

    assign is_addr  = (active_ir == IR_ADDR);
    assign is_write = (active_ir == IR_WRITE);
    assign is_read  = (active_ir == IR_READ);
`ifdef VJTAG_STATUS_EN
    assign is_status = (active_ir == IR_STATUS);
`else
    assign is_status = 1'b0;
`endif
    assign is_bypass = !(is_addr || is_write || is_read || is_status);

    // Read data landing this cycle is applied before any capture or FSM move.
    assign rd_hit     = (pf_state == PF_WAIT) && rd_valid;
    assign pf_eff     = rd_hit ? PF_READY : pf_state;
    assign rd_buf_eff = rd_hit ? rd_data : rd_buf;

    assign fetch = (virtual_state_uir && (ir_in == IR_READ) && (pf_state == PF_IDLE))
                || (virtual_state_udr && is_read && (pf_eff != PF_WAIT));

    assign addr_inc = fetch || (virtual_state_udr && is_write);

    assign tdo = is_bypass ? bypass_reg : shift_reg[0];

    // NOTE: always_comb assigns a default first so no path leaves the output unassigned (no latch).
    always_comb begin
        capture_value = '0;
        if (is_addr) begin
            capture_value = DATA_WIDTH'(addr);
        end else if (is_read) begin
            capture_value = rd_buf_eff;
`ifdef VJTAG_STATUS_EN
        end else if (is_status) begin
            capture_value = DATA_WIDTH'({wr_count, rd_count});
`endif
        end
    end

    always_comb begin
        ir_out      = '0;
        ir_out[0]   = wrap;
        ir_out[1]   = rd_err;
        ir_out[2]   = (pf_state == PF_WAIT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            active_ir  <= '0;
            bypass_reg <= 1'b0;
            shift_reg  <= '0;
            // NOTE: rd_buf is a plain register, not a RAM, so resetting it costs nothing and keeps captures defined.
            rd_buf     <= '0;
            addr       <= '0;
            wrap       <= 1'b0;
            rd_err     <= 1'b0;
            pf_state   <= PF_IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
        end else begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;

            if (rd_hit) begin
                rd_buf <= rd_data;
            end

            if (virtual_state_uir) begin
                active_ir <= ir_in;
                if (ir_in == IR_READ) begin
                    rd_err <= 1'b0;
                end
            end

            if (virtual_state_cdr) begin
                if (is_bypass) begin
                    bypass_reg <= 1'b0;
                end else begin
                    shift_reg <= capture_value;
                end
                if (is_read && (pf_state == PF_WAIT) && !rd_valid) begin
                    rd_err <= 1'b1;
                end
            end else if (virtual_state_sdr) begin
                if (is_bypass) begin
                    bypass_reg <= tdi;
                end else begin
                    shift_reg <= {tdi, shift_reg[DATA_WIDTH-1:1]};
                end
            end

            if (virtual_state_udr && is_addr) begin
                addr <= shift_reg[ADDR_WIDTH-1:0];
                wrap <= 1'b0;
            end else if (addr_inc) begin
                addr <= addr + ADDR_WIDTH'(1);
                if (addr == '1) begin
                    wrap <= 1'b1;
                end
            end

            if (virtual_state_udr && is_write) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= shift_reg;
            end

            if (fetch) begin
                rd_en   <= 1'b1;
                rd_addr <= addr;
            end

            if (virtual_state_uir && (ir_in != IR_READ)) begin
                pf_state <= PF_IDLE;
            end else if (fetch) begin
                pf_state <= PF_WAIT;
            end else begin
                pf_state <= pf_eff;
            end
        end
    end

`ifdef VJTAG_STATUS_EN
    // Saturating pulse counters for host-side traffic accounting.
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else if (virtual_state_udr && is_status) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (wr_en && (wr_count != '1)) begin
                wr_count <= wr_count + CNT_W'(1);
            end
            if (rd_en && (rd_count != '1)) begin
                rd_count <= rd_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vjtag_dr_engine.sv
// Self-checking bench for vjtag_dr_engine: write/read scoreboards plus a
// latency-programmable memory model driving rd_valid/rd_data.
module tb_vjtag_dr_engine;

    localparam int IRW = 3;
    localparam int DW  = 32;
    localparam int AW  = 16;

    logic           tck = 1'b0;
    logic           rst = 1'b1;
    logic           tdi = 1'b0;
    logic           tdo;
    logic [IRW-1:0] ir_in = '0;
    logic [IRW-1:0] ir_out;
    logic           cdr = 1'b0;
    logic           sdr = 1'b0;
    logic           udr = 1'b0;
    logic           uir = 1'b0;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic           rd_valid = 1'b0;
    logic [DW-1:0]  rd_data = '0;

    vjtag_dr_engine #(.IR_WIDTH(IRW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .tck               (tck),
        .rst               (rst),
        .tdi               (tdi),
        .tdo               (tdo),
        .ir_in             (ir_in),
        .ir_out            (ir_out),
        .virtual_state_cdr (cdr),
        .virtual_state_sdr (sdr),
        .virtual_state_udr (udr),
        .virtual_state_uir (uir),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .rd_en             (rd_en),
        .rd_addr           (rd_addr),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data)
    );

    always #5 tck = ~tck;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    wr_t           exp_wr[$];
    logic [DW-1:0] exp_rd[$];
    pend_t         pend[$];
    logic [DW-1:0] mem [0:255];
    int            mem_lat = 2;
    int            cyc = 0;
    wr_t           mon_e;

    // Write scoreboard and memory model, both on the falling edge.
    always @(negedge tck) begin
        cyc++;
        if (wr_en) begin
            n_assert++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_wr.pop_front();
                if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL write_beat: got addr=%h data=%h, required addr=%h data=%h",
                             wr_addr, wr_data, mon_e.addr, mon_e.data);
                end
            end
        end
        if (rd_en) begin
            pend.push_back('{due: cyc + mem_lat, data: mem[rd_addr[7:0]]});
        end
        rd_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rd_valid = 1'b1;
            rd_data  = pend[0].data;
            void'(pend.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge tck);
    endtask

    task automatic do_uir(input logic [IRW-1:0] code);
        ir_in = code;
        uir   = 1'b1;
        @(negedge tck);
        uir   = 1'b0;
    endtask

    task automatic scan_dr(input logic [DW-1:0] din, output logic [DW-1:0] dout);
        cdr = 1'b1;
        @(negedge tck);
        cdr = 1'b0;
        for (int i = 0; i < DW; i++) begin
            dout[i] = tdo;
            tdi     = din[i];
            sdr     = 1'b1;
            @(negedge tck);
        end
        sdr = 1'b0;
        udr = 1'b1;
        @(negedge tck);
        udr = 1'b0;
    endtask

    task automatic test_reset();
        idle(3);
        n_assert++;
        if ({tdo, ir_out, wr_en, rd_en, wr_addr, wr_data, rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tdo=%b ir_out=%h wr_en=%b rd_en=%b, required all 0",
                     tdo, ir_out, wr_en, rd_en);
        end
        rst = 1'b0;
        idle(2);
        n_assert++;
        if ({tdo, ir_out, wr_en, rd_en} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got tdo=%b ir_out=%h wr_en=%b rd_en=%b, required all 0",
                     tdo, ir_out, wr_en, rd_en);
        end
    endtask

    task automatic bypass_shift(input logic [2:0] din, input logic [2:0] exp_tdo, input string tag);
        logic saw_req;
        saw_req = 1'b0;
        cdr = 1'b1;
        @(negedge tck);
        cdr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (tdo !== exp_tdo[i]) begin
                n_fail++;
                $display("FAIL %s_tdo[%0d]: got %b, required %b", tag, i, tdo, exp_tdo[i]);
            end
            tdi = din[i];
            sdr = 1'b1;
            @(negedge tck);
            saw_req = saw_req | rd_en | wr_en;
        end
        sdr = 1'b0;
        n_assert++;
        if (saw_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_no_requests: got %b, required 0", tag, saw_req);
        end
    endtask

    task automatic test_bypass();
        bypass_shift(3'b101, 3'b010, "bypass");
    endtask

    task automatic test_write();
        logic [DW-1:0] cap;
        do_uir(3'd1);
        scan_dr(32'h0000_0010, cap);
        n_assert++;
        if (cap !== 32'h0) begin
            n_fail++;
            $display("FAIL addr_capture_initial: got %h, required %h", cap, 32'h0);
        end
        do_uir(3'd2);
        exp_wr.push_back('{addr: 16'h0010, data: 32'hA5A5_A5A5});
        scan_dr(32'hA5A5_A5A5, cap);
        n_assert++;
        if (cap !== 32'h0) begin
            n_fail++;
            $display("FAIL write_capture: got %h, required %h", cap, 32'h0);
        end
        exp_wr.push_back('{addr: 16'h0011, data: 32'h1234_5678});
        scan_dr(32'h1234_5678, cap);
        idle(2);
        n_assert++;
        if (exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL writes_pending: got %0d outstanding, required 0", exp_wr.size());
        end
        do_uir(3'd1);
        scan_dr(32'h0000_0012, cap);
        n_assert++;
        if (cap !== 32'h0000_0012) begin
            n_fail++;
            $display("FAIL addr_after_writes: got %h, required %h", cap, 32'h0000_0012);
        end
    endtask

    task automatic test_read();
        logic [DW-1:0] cap;
        logic [DW-1:0] e;
        mem[8'h10] = 32'hCAFE_F00D;
        mem[8'h11] = 32'hBEEF_0001;
        mem[8'h12] = 32'h5555_AAAA;
        mem_lat = 2;
        do_uir(3'd1);
        scan_dr(32'h0000_0010, cap);
        do_uir(3'd3);
        idle(4);
        exp_rd.push_back(32'hCAFE_F00D);
        scan_dr(32'h0, cap);
        e = exp_rd.pop_front();
        n_assert++;
        if (cap !== e) begin
            n_fail++;
            $display("FAIL read_word0: got %h, required %h", cap, e);
        end
        idle(4);
        exp_rd.push_back(32'hBEEF_0001);
        scan_dr(32'h0, cap);
        e = exp_rd.pop_front();
        n_assert++;
        if (cap !== e) begin
            n_fail++;
            $display("FAIL read_word1: got %h, required %h", cap, e);
        end
        idle(4);
        n_assert++;
        if (ir_out !== 3'b000) begin
            n_fail++;
            $display("FAIL read_status_clean: got %b, required %b", ir_out, 3'b000);
        end
    endtask

    task automatic test_read_error();
        logic [DW-1:0] cap;
        logic [DW-1:0] e;
        mem[8'h20] = 32'h1111_2222;
        mem[8'h21] = 32'h3333_4444;
        mem[8'h22] = 32'h0;
        do_uir(3'd1);
        scan_dr(32'h0000_0020, cap);
        mem_lat = 10;
        do_uir(3'd3);
        n_assert++;
        if (ir_out !== 3'b100) begin
            n_fail++;
            $display("FAIL wait_flag: got %b, required %b", ir_out, 3'b100);
        end
        exp_rd.push_back(32'h5555_AAAA);
        scan_dr(32'h0, cap);
        e = exp_rd.pop_front();
        n_assert++;
        if (cap !== e) begin
            n_fail++;
            $display("FAIL stale_capture: got %h, required %h", cap, e);
        end
        n_assert++;
        if (ir_out !== 3'b110) begin
            n_fail++;
            $display("FAIL rd_err_set: got %b, required %b", ir_out, 3'b110);
        end
        idle(14);
        n_assert++;
        if (ir_out !== 3'b010) begin
            n_fail++;
            $display("FAIL rd_err_sticky: got %b, required %b", ir_out, 3'b010);
        end
        do_uir(3'd3);
        n_assert++;
        if (ir_out !== 3'b000) begin
            n_fail++;
            $display("FAIL rd_err_cleared: got %b, required %b", ir_out, 3'b000);
        end
        exp_rd.push_back(32'h3333_4444);
        scan_dr(32'h0, cap);
        e = exp_rd.pop_front();
        n_assert++;
        if (cap !== e) begin
            n_fail++;
            $display("FAIL read_after_recover: got %h, required %h", cap, e);
        end
        idle(14);
        mem_lat = 2;
    endtask

    task automatic test_wrap();
        logic [DW-1:0] cap;
        do_uir(3'd1);
        scan_dr(32'h0000_FFFF, cap);
        n_assert++;
        if (cap !== 32'h0000_0023) begin
            n_fail++;
            $display("FAIL addr_after_reads: got %h, required %h", cap, 32'h0000_0023);
        end
        do_uir(3'd2);
        exp_wr.push_back('{addr: 16'hFFFF, data: 32'hDEAD_0001});
        scan_dr(32'hDEAD_0001, cap);
        idle(2);
        n_assert++;
        if (ir_out !== 3'b001) begin
            n_fail++;
            $display("FAIL wrap_set: got %b, required %b", ir_out, 3'b001);
        end
        do_uir(3'd1);
        scan_dr(32'h0000_0005, cap);
        n_assert++;
        if (cap !== 32'h0) begin
            n_fail++;
            $display("FAIL addr_wrapped: got %h, required %h", cap, 32'h0);
        end
        n_assert++;
        if (ir_out !== 3'b000) begin
            n_fail++;
            $display("FAIL wrap_cleared: got %b, required %b", ir_out, 3'b000);
        end
    endtask

`ifdef VJTAG_STATUS_EN
    task automatic test_status();
        logic [DW-1:0] cap;
        logic [DW-1:0] e;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        mem[8'h33] = 32'h0BAD_CAFE;
        do_uir(3'd1);
        scan_dr(32'h0000_0030, cap);
        do_uir(3'd2);
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back('{addr: AW'(16'h0030 + i), data: DW'(32'h7700_0000 + i)});
            scan_dr(DW'(32'h7700_0000 + i), cap);
        end
        do_uir(3'd3);
        idle(4);
        exp_rd.push_back(32'h0BAD_CAFE);
        scan_dr(32'h0, cap);
        e = exp_rd.pop_front();
        n_assert++;
        if (cap !== e) begin
            n_fail++;
            $display("FAIL status_read: got %h, required %h", cap, e);
        end
        idle(4);
        do_uir(3'd4);
        scan_dr(32'h0, cap);
        n_assert++;
        if (cap !== 32'h0003_0002) begin
            n_fail++;
            $display("FAIL status_counts: got %h, required %h", cap, 32'h0003_0002);
        end
        scan_dr(32'h0, cap);
        n_assert++;
        if (cap !== 32'h0) begin
            n_fail++;
            $display("FAIL status_cleared: got %h, required %h", cap, 32'h0);
        end
    endtask
`else
    task automatic test_status();
        do_uir(3'd4);
        bypass_shift(3'b011, 3'b110, "code4");
        do_uir(3'd7);
        bypass_shift(3'b001, 3'b010, "code7");
    endtask
`endif

    task automatic test_reset_mid_scan();
        logic [DW-1:0] cap;
        do_uir(3'd1);
        scan_dr(32'h0000_0040, cap);
        mem_lat = 10;
        do_uir(3'd3);
        cdr = 1'b1;
        @(negedge tck);
        cdr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tdi = 1'b1;
            sdr = 1'b1;
            @(negedge tck);
        end
        #2 rst = 1'b1;
        #1;
        sdr = 1'b0;
        n_assert++;
        if ({tdo, ir_out, wr_en, rd_en, wr_addr, wr_data, rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL midscan_reset_outputs: got tdo=%b ir_out=%h wr_addr=%h wr_data=%h rd_addr=%h, required all 0",
                     tdo, ir_out, wr_addr, wr_data, rd_addr);
        end
        idle(2);
        rst = 1'b0;
        idle(14);
        n_assert++;
        if ({ir_out, rd_en} !== '0) begin
            n_fail++;
            $display("FAIL late_rd_valid_ignored: got ir_out=%b rd_en=%b, required 0", ir_out, rd_en);
        end
        do_uir(3'd1);
        scan_dr(32'h0, cap);
        n_assert++;
        if (cap !== 32'h0) begin
            n_fail++;
            $display("FAIL addr_after_reset: got %h, required %h", cap, 32'h0);
        end
`ifdef VJTAG_STATUS_EN
        do_uir(3'd4);
        scan_dr(32'h0, cap);
        n_assert++;
        if (cap !== 32'h0) begin
            n_fail++;
            $display("FAIL status_after_reset: got %h, required %h", cap, 32'h0);
        end
`endif
        mem_lat = 2;
    endtask

    task automatic test_drain();
        idle(4);
        n_assert++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d writes %0d reads outstanding, required 0",
                     exp_wr.size(), exp_rd.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
        end
        test_reset();
        test_bypass();
        test_write();
        test_read();
        test_read_error();
        test_wrap();
        test_status();
        test_reset_mid_scan();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vjtag_dr_engine.md
Name: vjtag_dr_engine

Overview:
- Parametrised data-register engine for the Virtual JTAG instance; clocked by its tck.
- Decodes the latched virtual IR and shifts DATA_WIDTH-bit DRs.
- Generates auto-incrementing memory write/read requests toward a frame/line buffer, so host-side tooling can load pixels and read back downscaled results.
- Generalises the fixed 2-bit-IR usage to configurable IR, data and address widths, and adds read prefetch and sticky error flags.

Parameters:
- IR_WIDTH, 3, virtual IR width; must be >= 3.
- DATA_WIDTH, 32, DR and memory data width.
- ADDR_WIDTH, 16, memory address width; must be <= DATA_WIDTH.

Ports:
- tck  in  1  JTAG virtual clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- tdi  in  1  serial data from the virtual JTAG.
- tdo  out  1  serial data to the virtual JTAG.
- ir_in  in  IR_WIDTH  current virtual instruction.
- ir_out  out  IR_WIDTH  status captured at Capture-IR.
- virtual_state_cdr/sdr/udr/uir  in  1 each  virtual TAP state strobes.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_data  out  DATA_WIDTH  write data.
- rd_en  out  1  one-cycle read request.
- rd_addr  out  ADDR_WIDTH  read address.
- rd_valid  in  1  read data valid; latency >= 1 cycle after rd_en.
- rd_data  in  DATA_WIDTH  read data.

Behaviour:
- Reset: all registers 0 and all outputs 0; active instruction = BYPASS; prefetch FSM = PF_IDLE.
- Reset mid-scan drops the shift contents and any pending read; a late rd_valid after reset is ignored.
- Instruction codes:
  - 0 BYPASS
  - 1 ADDR
  - 2 WRITE
  - 3 READ
  - 4 STATUS (optional feature)
  - all other codes behave as BYPASS.
- Instruction latching: on uir, active instruction <= ir_in.
- DR length:
  - BYPASS: 1-bit register, captures 0.
  - All other instructions: DATA_WIDTH-bit shift_reg.
- Shifting: on sdr, shift_reg <= {tdi, shift_reg[DATA_WIDTH-1:1]}, LSB first. tdo = shift_reg[0] (or the bypass bit), combinational from the register.
- Capture values (on cdr):
  - ADDR: zero-extended addr.
  - WRITE: 0.
  - READ: rd_buf.
  - STATUS: see Optional Feature.
- ADDR: on udr, addr <= shift_reg[ADDR_WIDTH-1:0]; clears the wrap flag.
- WRITE: on udr, the next cycle drives wr_en=1, wr_addr=addr, wr_data=shift_reg; addr increments in that same cycle.
- READ prefetch FSM:
  - PF_IDLE -> PF_WAIT: on uir with ir_in==READ, or on udr while READ is active. Issue rd_en=1 with rd_addr=addr for one cycle, then addr += 1.
  - PF_WAIT -> PF_READY: on rd_valid; rd_buf <= rd_data.
  - PF_READY -> PF_WAIT: on the next udr in READ (prefetch next word).
  - Any non-READ uir -> PF_IDLE.
- Read ordering: the first capture after selecting READ returns mem[addr_at_select]. Each following scan returns the next word.
- Read error: cdr in READ while in PF_WAIT captures stale rd_buf and sets sticky rd_err. The FSM stays in PF_WAIT; the late rd_valid still loads rd_buf.
- Address wrap: addr increments modulo 2^ADDR_WIDTH. 2^ADDR_WIDTH-1 -> 0 sets sticky wrap.
- Simultaneous events: rd_valid coinciding with cdr in PF_WAIT loads rd_buf first and captures the new data, with no error. udr and rd_valid in the same cycle: rd_valid is applied before the FSM transition.
- ir_out: bit0 = wrap, bit1 = rd_err, bit2 = (FSM==PF_WAIT); higher bits 0.
- Sticky flag clearing: rd_err is cleared by uir selecting READ; wrap is cleared only by ADDR udr.

Optional Feature:
- Macro: VJTAG_STATUS_EN.
- Defined: instruction 4 STATUS is enabled.
  - Capture = {wr_count[DATA_WIDTH/2-1:0], rd_count[DATA_WIDTH/2-1:0]}.
  - The counters count wr_en and rd_en pulses, saturate at all-ones, and are cleared by reset or by udr in STATUS.
- Undefined: code 4 acts as BYPASS; no counters are synthesised.

Test Plan:
- Reset then BYPASS scan shifting 1,0,1 -> tdo emits 0,1,0 (one-bit delay); wr_en and rd_en stay 0.
- ADDR scan 0x0010, then WRITE scans 0xA5A5A5A5 and 0x12345678 -> wr_en pulses at addr 0x0010 then 0x0011, with matching data; a subsequent ADDR capture returns 0x00000012.
- Memory model with 2-cycle latency holding mem[0x10]=0xCAFEF00D and mem[0x11]=0xBEEF0001; select READ after ADDR=0x10; two DR scans -> tdo returns 0xCAFEF00D then 0xBEEF0001; rd_err=0.
- Memory latency of 10 cycles, READ cdr immediately after uir -> stale rd_buf captured; ir_out bit1=1 at the next Capture-IR; the flag clears on reselecting READ.
- ADDR=0xFFFF then one WRITE -> wr_addr=0xFFFF, addr wraps to 0, ir_out bit0=1; the next ADDR scan clears it.
- With VJTAG_STATUS_EN: 3 writes and 2 reads, then STATUS capture -> 0x00030002; reassert rst mid-scan -> all outputs 0 and the counters cleared.
